cond_unit_ctx: RTL and testbench

//  Parametrised ARM condition unit for the multicycle datapath. Holds the NZCV(+ext) flag register in

---
 rtl/cond_unit_ctx_pkg.sv | 26 ++
 rtl/cond_unit_ctx_stack.sv | 95 +++++++++
 rtl/cond_unit_ctx.sv | 122 ++++++++++++
 tb/tb_cond_unit_ctx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cond_unit_ctx_pkg.sv
// Shared condition-code encodings and flag bit positions for the condition unit.
package cond_defs;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_ctx_stack.sv
// LIFO of saved flag contexts: push, pop and push+pop exchange of the top entry,
// with full/empty status and a sticky error for illegal operations.
module flag_ctx_stack #(
   parameter int W     = 4,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         load,
   output logic         empty,
   output logic         full,
   output logic         err
);

   localparam int PW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [PW-1:0] ptr_r;
   logic          err_r;

   logic          do_push_s;
   logic          do_pop_s;
   logic          do_xchg_s;
   logic          illegal_s;
   logic          mem_we_s;
   logic [IW-1:0] top_idx_s;
   logic [IW-1:0] wr_idx_s;

   assign empty = (ptr_r == '0);
   assign full  = (ptr_r == PW'(DEPTH));
   assign err   = err_r;
   assign load  = do_pop_s | do_xchg_s;
   assign top   = mem_r[top_idx_s];

   // Operation decode; illegal requests leave pointer and storage untouched.
   always_comb begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
      do_xchg_s = 1'b0;
      illegal_s = 1'b0;
      if (push && !pop) begin
         do_push_s = !full;
         illegal_s = full;
      end else if (pop && !push) begin
         do_pop_s  = !empty;
         illegal_s = empty;
      end else if (push && pop) begin
         do_xchg_s = !empty;
         illegal_s = empty;
      end else begin
         illegal_s = 1'b0;
      end
      if (empty) begin
         top_idx_s = '0;
      end else begin
         top_idx_s = IW'(ptr_r - PW'(1));
      end
      if (do_xchg_s) begin
         wr_idx_s = top_idx_s;
      end else begin
         wr_idx_s = IW'(ptr_r);
      end
      mem_we_s = do_push_s | do_xchg_s;
   end

   // Stack pointer and sticky error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_r <= '0;
         err_r <= 1'b0;
      end else begin
         if (do_push_s) begin
            ptr_r <= ptr_r + PW'(1);
         end else if (do_pop_s) begin
            ptr_r <= ptr_r - PW'(1);
         end
         if (illegal_s) begin
            err_r <= 1'b1;
         end
      end
   end

   // Entry storage is deliberately not reset; the pointer defines validity.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[wr_idx_s] <= din;
      end
   end

endmodule

// File: rtl/cond_unit_ctx.sv
// ARM condition unit: grouped flag register, condition evaluation, write-enable
// gating for the multicycle controller and a flag-context stack for exceptions.
module cond_unit_ctx
   import cond_defs::*;
#(
   parameter int NFLAGS     = 4,
   parameter int NGROUPS    = 2,
   parameter int DEPTH      = 4,
   parameter bit MULTICYCLE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        Cond,
   input  logic [NFLAGS-1:0] ALUFlags,
   input  logic [NGROUPS-1:0] FlagW,
   input  logic              PCS,
   input  logic              NextPC,
   input  logic              RegW,
   input  logic              MemW,
   input  logic              FlagPush,
   input  logic              FlagPop,
   output logic              PCWrite,
   output logic              RegWrite,
   output logic              MemWrite,
   output logic              CondEx,
   output logic [NFLAGS-1:0] Flags,
   output logic              StackEmpty,
   output logic              StackFull,
   output logic              StackErr
);

   localparam int GW = NFLAGS / NGROUPS;

   logic [NFLAGS-1:0] flags_r;
   logic [NFLAGS-1:0] flags_nxt_s;
   logic [NFLAGS-1:0] stack_top_s;
   logic              stack_load_s;
   logic              cond_ex_s;
   logic              cond_ex_r;
   logic              gate_s;
   logic              n_s, z_s, c_s, v_s;

   assign n_s = flags_r[FLAG_N];
   assign z_s = flags_r[FLAG_Z];
   assign c_s = flags_r[FLAG_C];
   assign v_s = flags_r[FLAG_V];

   // Condition decode against the architectural NZCV bits.
   always_comb begin
      cond_ex_s = 1'b0;
      case (Cond)
         COND_EQ: cond_ex_s = z_s;
         COND_NE: cond_ex_s = !z_s;
         COND_CS: cond_ex_s = c_s;
         COND_CC: cond_ex_s = !c_s;
         COND_MI: cond_ex_s = n_s;
         COND_PL: cond_ex_s = !n_s;
         COND_VS: cond_ex_s = v_s;
         COND_VC: cond_ex_s = !v_s;
         COND_HI: cond_ex_s = c_s && !z_s;
         COND_LS: cond_ex_s = !c_s || z_s;
         COND_GE: cond_ex_s = (n_s == v_s);
         COND_LT: cond_ex_s = (n_s != v_s);
         COND_GT: cond_ex_s = !z_s && (n_s == v_s);
         COND_LE: cond_ex_s = z_s || (n_s != v_s);
         COND_AL: cond_ex_s = 1'b1;
         default: cond_ex_s = 1'b0;
      endcase
   end

   assign gate_s   = MULTICYCLE ? cond_ex_r : cond_ex_s;
   assign CondEx   = gate_s;
   assign RegWrite = RegW & gate_s;
   assign MemWrite = MemW & gate_s;
   assign PCWrite  = (PCS & gate_s) | NextPC;
   assign Flags    = flags_r;

   // Restores from the stack take priority over ALU group writes; group
   // writes always use the combinational result, even in multicycle mode.
   always_comb begin
      flags_nxt_s = flags_r;
      if (stack_load_s) begin
         flags_nxt_s = stack_top_s;
      end else begin
         for (int g = 0; g < NGROUPS; g++) begin
            if (FlagW[g] && cond_ex_s) begin
               flags_nxt_s[g*GW +: GW] = ALUFlags[g*GW +: GW];
            end else begin
               flags_nxt_s[g*GW +: GW] = flags_r[g*GW +: GW];
            end
         end
      end
   end

   // Flag register and registered condition result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_r   <= '0;
         cond_ex_r <= 1'b0;
      end else begin
         flags_r   <= flags_nxt_s;
         cond_ex_r <= cond_ex_s;
      end
   end

   flag_ctx_stack #(
      .W     (NFLAGS),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (FlagPush),
      .pop   (FlagPop),
      .din   (flags_r),
      .top   (stack_top_s),
      .load  (stack_load_s),
      .empty (StackEmpty),
      .full  (StackFull),
      .err   (StackErr)
   );

endmodule

// File: tb/tb_cond_unit_ctx.sv
// Directed and random checks of cond_unit_ctx against a queue-based reference model.
module tb_cond_unit_ctx;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cond;
   logic [3:0] alu;
   logic [1:0] fw;
   logic       pcs, npc, regw, memw, push, pop;
   logic       PCWrite, RegWrite, MemWrite, CondEx, StackEmpty, StackFull, StackErr;
   logic [3:0] Flags;

   int vectors = 0;
   int miscompares = 0;

   logic [3:0] m_flags;
   logic       m_cxr;
   logic       m_err;
   logic [3:0] m_stack[$];

   always #5 clk = ~clk;

   cond_unit_ctx #(.NFLAGS(4), .NGROUPS(2), .DEPTH(DEPTH), .MULTICYCLE(1'b1)) dut (
      .clk(clk), .reset(reset), .Cond(cond), .ALUFlags(alu), .FlagW(fw),
      .PCS(pcs), .NextPC(npc), .RegW(regw), .MemW(memw),
      .FlagPush(push), .FlagPop(pop),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .Flags(Flags), .StackEmpty(StackEmpty), .StackFull(StackFull), .StackErr(StackErr)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic set_in(input logic [3:0] c, input logic [3:0] a, input logic [1:0] w,
                         input logic pu, input logic po);
      cond = c; alu = a; fw = w; push = pu; pop = po;
   endtask

   task automatic model_clear();
      m_flags = 4'd0; m_cxr = 1'b0; m_err = 1'b0; m_stack.delete();
   endtask

   // One clock: check all outputs mid-cycle, advance the model, land #1 after the edge.
   task automatic step();
      logic       cx;
      logic [3:0] mask;
      logic [3:0] tmp;
      @(negedge clk);
      chk("RegWrite", RegWrite, regw & m_cxr);
      chk("MemWrite", MemWrite, memw & m_cxr);
      chk("PCWrite", PCWrite, (pcs & m_cxr) | npc);
      chk("CondEx", CondEx, m_cxr);
      chk("Flags", Flags, m_flags);
      chk("StackEmpty", StackEmpty, m_stack.size() == 0);
      chk("StackFull", StackFull, m_stack.size() == DEPTH);
      chk("StackErr", StackErr, m_err);
      cx = cond_ok(cond, m_flags);
      mask = {{2{fw[1]}}, {2{fw[0]}}} & {4{cx}};
      if (push && !pop) begin
         if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
         else m_err = 1'b1;
         m_flags = (m_flags & ~mask) | (alu & mask);
      end else if (pop && !push) begin
         if (m_stack.size() > 0) m_flags = m_stack.pop_back();
         else begin
            m_err = 1'b1;
            m_flags = (m_flags & ~mask) | (alu & mask);
         end
      end else if (push && pop) begin
         if (m_stack.size() > 0) begin
            tmp = m_stack[$];
            m_stack[$] = m_flags;
            m_flags = tmp;
         end else begin
            m_err = 1'b1;
            m_flags = (m_flags & ~mask) | (alu & mask);
         end
      end else begin
         m_flags = (m_flags & ~mask) | (alu & mask);
      end
      m_cxr = cx;
      @(posedge clk);
      #1;
   endtask

   task automatic async_reset();
      #1 reset = 1'b0;
      #1;
      model_clear();
      chk("rst_Flags", Flags, 4'd0);
      chk("rst_StackEmpty", StackEmpty, 1'b1);
      chk("rst_StackFull", StackFull, 1'b0);
      chk("rst_StackErr", StackErr, 1'b0);
      chk("rst_CondEx", CondEx, 1'b0);
      #1 reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      {pcs, npc, regw, memw} = 4'b0000;
      set_in(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
      model_clear();
      #2;
      chk("init_Flags", Flags, 4'd0);
      chk("init_StackEmpty", StackEmpty, 1'b1);
      chk("init_StackErr", StackErr, 1'b0);
      #10 reset = 1'b1;
      @(posedge clk);
      #1;

      // Sticky error, two pushes, then asynchronous reset mid-run
      set_in(4'b1110, 4'b0110, 2'b11, 1'b0, 1'b1); step();
      chk("err_set", StackErr, 1'b1);
      set_in(4'b1110, 4'b1001, 2'b11, 1'b1, 1'b0); step();
      set_in(4'b1111, 4'b0000, 2'b00, 1'b1, 1'b0); step();
      set_in(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
      async_reset();

      // Registered CondEx gating
      set_in(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0); step();
      set_in(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0); step();
      regw = 1'b1;
      set_in(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      #1 chk("eq_cyc0_RegWrite", RegWrite, 1'b0);
      step();
      #1 chk("eq_cyc1_RegWrite", RegWrite, 1'b1);
      set_in(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0);
      #1 chk("ne_cyc0_RegWrite", RegWrite, 1'b1);
      step();
      #1 chk("ne_cyc1_RegWrite", RegWrite, 1'b0);
      step();
      regw = 1'b0;

      // Group write and NV suppression
      set_in(4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0); step();
      chk("grp_write", Flags, 4'b1100);
      set_in(4'b1111, 4'b0000, 2'b11, 1'b0, 1'b0); step();
      chk("nv_nowrite", Flags, 4'b1100);

      // Push, overwrite, pop
      set_in(4'b1110, 4'b1010, 2'b11, 1'b0, 1'b0); step();
      set_in(4'b1111, 4'b0000, 2'b00, 1'b1, 1'b0); step();
      set_in(4'b1110, 4'b0001, 2'b11, 1'b0, 1'b0); step();
      chk("overwrite", Flags, 4'b0001);
      set_in(4'b1110, 4'b0110, 2'b11, 1'b0, 1'b1); step();
      chk("pop_restore", Flags, 4'b1010);
      chk("pop_empty", StackEmpty, 1'b1);

      // Fill to DEPTH, overflow, drain in LIFO order
      for (int i = 0; i < 5; i++) begin
         set_in(4'b1110, 4'(i + 1), 2'b11, 1'b1, 1'b0); step();
         if (i == 3) chk("full_after_4", StackFull, 1'b1);
      end
      chk("overflow_err", StackErr, 1'b1);
      chk("overflow_flags", Flags, 4'd5);
      set_in(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1); step();
      chk("lifo_0", Flags, 4'd3);
      step(); chk("lifo_1", Flags, 4'd2);
      step(); chk("lifo_2", Flags, 4'd1);
      step(); chk("lifo_3", Flags, 4'b1010);

      // Exchange
      set_in(4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0); step();
      set_in(4'b1110, 4'b0011, 2'b11, 1'b1, 1'b0); step();
      chk("pre_xchg", Flags, 4'b0011);
      set_in(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1); step();
      chk("xchg_flags", Flags, 4'b1000);
      chk("xchg_ptr", StackEmpty, 1'b0);
      set_in(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1); step();
      chk("xchg_top", Flags, 4'b0011);
      set_in(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
      async_reset();
      set_in(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1); step();
      chk("pop_empty_err", StackErr, 1'b1);
      set_in(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
      async_reset();

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         set_in(4'($urandom_range(0, 15)), 4'($urandom), 2'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
         {pcs, npc, regw, memw} = 4'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
